// File: rtl/morph_filter_3x3.sv
// -----------------------------------------------------------------------------
// morph_filter_3x3
//
// Streaming 3x3 grey-scale morphology on a raster pixel stream:
//   mode = 0 -> erosion  (minimum over the 3x3 neighbourhood)
//   mode = 1 -> dilation (maximum over the 3x3 neighbourhood)
// Two line buffers of IMG_W pixels feed a 3x3 window register. The block
// emits exactly one filtered pixel per input pixel, in raster order.
//
// Optional feature macro: MORPH_BINARY_EN
//   defined   -> m_data is all-ones when the min/max result >= THRESH, else 0
//   undefined -> m_data is the raw min/max result
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous reset, active low
//   mode       0 = erode, 1 = dilate; sampled with the accepted SOF pixel
//   s_valid    input pixel valid
//   s_ready    block can accept a pixel
//   s_sof      accepted pixel is pixel (0,0) of a new frame
//   s_data     input pixel
//   m_valid    output pixel strobe (no back-pressure)
//   m_data     filtered pixel
//   m_sof      output pixel (0,0)
//   m_eol      output pixel in the last column
//   m_eof      last output pixel of the frame
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = FLUSH)
//
// Handshake: an input transfer happens on a rising edge where
// s_valid & s_ready are both 1; s_valid may be raised without waiting for
// s_ready, and s_ready never depends combinationally on s_valid. The output
// side is a plain strobe: m_valid is high for one cycle per pixel and the
// sink must take it.
// -----------------------------------------------------------------------------
module morph_filter_3x3 #(
  parameter int                DATA_W = 10,
  parameter int                IMG_W  = 640,
  parameter int                IMG_H  = 480,
  parameter logic [DATA_W-1:0] THRESH = DATA_W'(10'h200)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof,
  output logic [1:0]        dbg_state
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  // Centre row runs from -2 up to IMG_H-1, so it carries a sign bit.
  localparam int ROW_W = $clog2(IMG_H) + 2;

  localparam logic [COL_W-1:0]        COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]        COL_PEN   = COL_W'(IMG_W - 2);
  localparam logic [COL_W-1:0]        COL_ONE   = COL_W'(1);
  localparam logic signed [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic signed [ROW_W-1:0] ROW_PEN   = ROW_W'(IMG_H - 2);
  localparam logic signed [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
  // Centre position of raster index n=0 is k = -(IMG_W+1), i.e. row -2,
  // column IMG_W-1.
  localparam logic signed [ROW_W-1:0] ROW_START = ROW_W'(-2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state;
  logic   mode_q;

  // Centre coordinate (row, column) of the next raster step to process.
  logic signed [ROW_W-1:0] kr_q;
  logic [COL_W-1:0]        kc_q;

  // ---------------------------------------------------------------------------
  // Step control: a "step" is one accepted pixel or one virtual flush pixel.
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic                    sof_acc;
  logic                    abort;
  logic                    step;
  logic signed [ROW_W-1:0] cur_kr;
  logic [COL_W-1:0]        cur_kc;
  logic signed [ROW_W-1:0] nxt_kr;
  logic [COL_W-1:0]        nxt_kc;
  logic [COL_W-1:0]        wr_col;
  logic                    last_in;
  logic                    last_flush;
  logic [DATA_W-1:0]       pix;

  always_comb begin
    accept  = s_valid & s_ready;
    sof_acc = accept & s_sof;
    abort   = sof_acc & (state == ST_RUN);

    step = 1'b0;
    case (state)
      ST_IDLE:  step = sof_acc;
      ST_RUN:   step = accept;
      ST_FLUSH: step = 1'b1;
      default:  step = 1'b0;
    endcase

    // An SOF pixel always restarts the raster at n = 0.
    cur_kr = sof_acc ? ROW_START : kr_q;
    cur_kc = sof_acc ? COL_LAST  : kc_q;

    if (cur_kc == COL_LAST) begin
      nxt_kc = '0;
      nxt_kr = cur_kr + ROW_ONE;
    end else begin
      nxt_kc = cur_kc + COL_ONE;
      nxt_kr = cur_kr;
    end

    // The input pixel sits IMG_W+1 positions ahead of the centre, so its
    // column is (centre column + 1) mod IMG_W, which is exactly nxt_kc.
    wr_col = nxt_kc;

    // Last real input pixel n = W*H-1 has centre k = W*H-W-2.
    last_in    = (cur_kr == ROW_PEN)  && (cur_kc == COL_PEN);
    // Last virtual pixel has centre k = W*H-1.
    last_flush = (cur_kr == ROW_LAST) && (cur_kc == COL_LAST);

    // Virtual pixels carry a fixed value; every tap they reach is masked.
    pix = (state == ST_FLUSH) ? '0 : s_data;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s_ready <= 1'b1;
      mode_q  <= 1'b0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      if (step) begin
        kr_q <= nxt_kr;
        kc_q <= nxt_kc;
      end
      if (sof_acc) begin
        mode_q <= mode;
      end
      case (state)
        ST_IDLE: begin
          if (sof_acc) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // An SOF pixel starts at n=0 and can never be the last pixel.
          if (accept && !s_sof && last_in) begin
            state   <= ST_FLUSH;
            s_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (last_flush) begin
            state   <= ST_IDLE;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Line buffers: lb0 holds the row above the input, lb1 the row above that.
  // Not reset; stale contents are always masked at the window.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] col_top;
  logic [DATA_W-1:0] col_mid;

  assign col_top = lb1[wr_col];
  assign col_mid = lb0[wr_col];

  always_ff @(posedge clk) begin
    if (step) begin
      lb0[wr_col] <= pix;
      lb1[wr_col] <= col_mid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: 3x3 window, indexed [row][col]; column 2 is the newest. After a
  // step the centre tap win[1][1] is the pixel at k = cur_k, so the edge
  // masks are taken from cur_k.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] win [3][3];
  logic              win_valid;
  logic              msk_t;
  logic              msk_b;
  logic              msk_l;
  logic              msk_r;
  logic              win_sof;
  logic              win_eol;
  logic              win_eof;

  always_ff @(posedge clk) begin
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= col_top;
      win[1][2] <= col_mid;
      win[2][2] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      msk_t     <= 1'b0;
      msk_b     <= 1'b0;
      msk_l     <= 1'b0;
      msk_r     <= 1'b0;
      win_sof   <= 1'b0;
      win_eol   <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      // Negative centre rows are warm-up positions with no output.
      win_valid <= step && !cur_kr[ROW_W-1];
      if (step) begin
        msk_t   <= (cur_kr == '0);
        msk_b   <= (cur_kr == ROW_LAST);
        msk_l   <= (cur_kc == '0);
        msk_r   <= (cur_kc == COL_LAST);
        win_sof <= (cur_kr == '0) && (cur_kc == '0);
        win_eol <= (cur_kc == COL_LAST);
        win_eof <= (cur_kr == ROW_LAST) && (cur_kc == COL_LAST);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: masked min/max tree.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] pick(input logic              max_sel,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if (max_sel) begin
      return (a > b) ? a : b;
    end
    return (a < b) ? a : b;
  endfunction

  logic [DATA_W-1:0] ident;
  logic [DATA_W-1:0] tap [3][3];
  logic [DATA_W-1:0] lvl1 [4];
  logic [DATA_W-1:0] lvl2 [2];
  logic [DATA_W-1:0] mm_res;
  logic [DATA_W-1:0] out_val;

  always_comb begin
    // Identity of the reduction: all-ones for min, zero for max.
    ident = {DATA_W{~mode_q}};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if ((r == 0 && msk_t) || (r == 2 && msk_b) ||
            (c == 0 && msk_l) || (c == 2 && msk_r)) begin
          tap[r][c] = ident;
        end else begin
          tap[r][c] = win[r][c];
        end
      end
    end
    lvl1[0] = pick(mode_q, tap[0][0], tap[0][1]);
    lvl1[1] = pick(mode_q, tap[0][2], tap[1][0]);
    lvl1[2] = pick(mode_q, tap[1][1], tap[1][2]);
    lvl1[3] = pick(mode_q, tap[2][0], tap[2][1]);
    lvl2[0] = pick(mode_q, lvl1[0], lvl1[1]);
    lvl2[1] = pick(mode_q, lvl1[2], lvl1[3]);
    mm_res  = pick(mode_q, pick(mode_q, lvl2[0], lvl2[1]), tap[2][2]);
  end

`ifdef MORPH_BINARY_EN
  assign out_val = (mm_res >= THRESH) ? {DATA_W{1'b1}} : '0;
`else
  assign out_val = mm_res;
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
`endif

  // A mid-frame SOF kills the window that would otherwise be emitted now.
  logic emit;
  assign emit = win_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      m_valid <= emit;
      m_sof   <= emit && win_sof;
      m_eol   <= emit && win_eol;
      m_eof   <= emit && win_eof;
      if (emit) begin
        m_data <= out_val;
      end
    end
  end

endmodule

// File: tb/tb_morph_filter_3x3.sv
module tb_morph_filter_3x3;

  localparam int DW   = 10;
  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int NPIX = IW * IH;
  localparam int OW   = DW + 3;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          mode    = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sof   = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;
  logic [1:0]    dbg_state;

  morph_filter_3x3 #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_eof     (m_eof),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard state ----------------
  logic [OW-1:0] obs_q[$];
  int            obs_cyc[$];
  logic [OW-1:0] exp_q[$];
  logic [DW-1:0] img[NPIX];
  int            bad_flag_cnt  = 0;
  int            ready_low_cnt = 0;
  int            n_checks      = 0;
  int            n_pass        = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      obs_q.push_back({m_data, m_sof, m_eol, m_eof});
      obs_cyc.push_back(cyc);
    end else if (m_sof || m_eol || m_eof) begin
      bad_flag_cnt++;
    end
    if (!s_ready) ready_low_cnt++;
  end

  // ---------------- reference model ----------------
  // Direct neighbourhood min/max over in-image pixels of img[].
  function automatic void build_exp(input logic md);
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
      int r = k / IW;
      int c = k % IW;
      logic [DW-1:0] acc = md ? '0 : '1;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          int rr = r + dr;
          int cc = c + dc;
          if (rr >= 0 && rr < IH && cc >= 0 && cc < IW) begin
            logic [DW-1:0] v = img[rr * IW + cc];
            if (md && v > acc) acc = v;
            if (!md && v < acc) acc = v;
          end
        end
      end
`ifdef MORPH_BINARY_EN
      acc = (acc >= DW'(10'h200)) ? '1 : '0;
`endif
      exp_q.push_back({acc, k == 0, c == IW - 1, k == NPIX - 1});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_data  = DW'($urandom);
    end
  endtask

  task automatic put_pix(input logic [DW-1:0] d, input logic sof,
                         input logic md, output int acc_cyc);
    int guard = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    mode    = md;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      $display("FAIL put_pix_ready actual s_ready=0 required s_ready=1 within 50 cycles");
    end
    acc_cyc = cyc;
  endtask

  // Sends img[] as one frame; non-SOF pixels drive a random mode value to
  // show that mode is held from the SOF pixel. Returns the accept cycle of
  // the pixel whose window centre is output pixel 0.
  task automatic send_frame(input logic md, input logic gaps, output int acc_k0);
    int acc;
    acc_k0 = -1;
    for (int n = 0; n < NPIX; n++) begin
      if (gaps && n > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      put_pix(img[n], n == 0, (n == 0) ? md : 1'($urandom), acc);
      if (n == IW + 1) acc_k0 = acc;
    end
    idle(1);
  endtask

  task automatic wait_out(input int n);
    int guard = 0;
    while (obs_q.size() < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL reset_s_ready actual=%b required=1", s_ready);
    else n_pass++;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL reset_m_valid actual=%b required=0", m_valid);
    else n_pass++;
    n_checks++;
    if (m_data !== '0) $display("FAIL reset_m_data actual=%h required=000", m_data);
    else n_pass++;
    n_checks++;
    if ({m_sof, m_eol, m_eof} !== 3'b000)
      $display("FAIL reset_flags actual=%b required=000", {m_sof, m_eol, m_eof});
    else n_pass++;
  endtask

  task automatic test_uniform();
    int acc_k0;
    for (int i = 0; i < NPIX; i++) img[i] = 10'h3FF;
    build_exp(1'b0);
    obs_q.delete();
    obs_cyc.delete();
    ready_low_cnt = 0;
    send_frame(1'b0, 1'b0, acc_k0);
    wait_out(NPIX);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL uniform_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL uniform_px%0d actual data=%h flags=%b required data=%h flags=%b",
                 i, obs_q[i][OW-1:3], obs_q[i][2:0], exp_q[i][OW-1:3], exp_q[i][2:0]);
      else n_pass++;
    end
    n_checks++;
    if (ready_low_cnt !== IW + 1)
      $display("FAIL uniform_ready_low actual=%0d required=%0d", ready_low_cnt, IW + 1);
    else n_pass++;
    if (obs_cyc.size() > 0) begin
      n_checks++;
      if (obs_cyc[0] - acc_k0 !== 2)
        $display("FAIL uniform_latency actual=%0d required=2", obs_cyc[0] - acc_k0);
      else n_pass++;
    end
  endtask

  task automatic test_point(input string name, input logic [DW-1:0] bg,
                            input logic [DW-1:0] pt, input int pidx, input logic md);
    int acc_k0;
    for (int i = 0; i < NPIX; i++) img[i] = bg;
    img[pidx] = pt;
    build_exp(md);
    obs_q.delete();
    send_frame(md, 1'b0, acc_k0);
    wait_out(NPIX);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL %s_count actual=%0d required=%0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL %s_px%0d actual data=%h flags=%b required data=%h flags=%b",
                 name, i, obs_q[i][OW-1:3], obs_q[i][2:0], exp_q[i][OW-1:3], exp_q[i][2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_random_frames();
    int acc_k0;
    int acc;
    for (int f = 0; f < 6; f++) begin
      logic md = 1'($urandom);
      for (int i = 0; i < NPIX; i++)
        img[i] = (f < 3) ? DW'($urandom) : DW'($urandom_range(500, 520));
      build_exp(md);
      obs_q.delete();
      // Non-SOF pixels in IDLE must be dropped.
      for (int j = 0; j < 2; j++) put_pix(DW'($urandom), 1'b0, 1'($urandom), acc);
      send_frame(md, 1'b1, acc_k0);
      wait_out(NPIX);
      n_checks++;
      if (obs_q.size() !== exp_q.size())
        $display("FAIL rand%0d_count actual=%0d required=%0d", f, obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL rand%0d_px%0d actual data=%h flags=%b required data=%h flags=%b",
                   f, i, obs_q[i][OW-1:3], obs_q[i][2:0], exp_q[i][OW-1:3], exp_q[i][2:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back_abort();
    int acc_k0;
    int acc;
    logic md = 1'($urandom);
    obs_q.delete();
    // Six pixels of a frame, then the 7th pixel carries SOF of a new frame.
    put_pix(DW'($urandom), 1'b1, ~md, acc);
    for (int j = 1; j < 6; j++) put_pix(DW'($urandom), 1'b0, 1'($urandom), acc);
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    build_exp(md);
    send_frame(md, 1'b0, acc_k0);
    wait_out(NPIX);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL abort_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL abort_px%0d actual data=%h flags=%b required data=%h flags=%b",
                 i, obs_q[i][OW-1:3], obs_q[i][2:0], exp_q[i][OW-1:3], exp_q[i][2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_flush();
    int acc_k0;
    int acc;
    int guard = 0;
    logic md;
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    for (int n = 0; n < NPIX; n++) put_pix(img[n], n == 0, 1'b0, acc);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    while (s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL flush_entry actual s_ready=%b required=0", s_ready);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) $display("FAIL rst_flush_m_valid actual=%b required=0", m_valid);
    else n_pass++;
    n_checks++;
    if (s_ready !== 1'b1) $display("FAIL rst_flush_s_ready actual=%b required=1", s_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    for (int j = 0; j < 3; j++) put_pix(DW'($urandom), 1'b0, 1'($urandom), acc);
    idle(10);
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL rst_drop_count actual=%0d required=0", obs_q.size());
    else n_pass++;
    md = 1'($urandom);
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
    build_exp(md);
    obs_q.delete();
    send_frame(md, 1'b0, acc_k0);
    wait_out(NPIX);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rst_frame_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rst_frame_px%0d actual data=%h flags=%b required data=%h flags=%b",
                 i, obs_q[i][OW-1:3], obs_q[i][2:0], exp_q[i][OW-1:3], exp_q[i][2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_flags_idle();
    n_checks++;
    if (bad_flag_cnt !== 0)
      $display("FAIL flags_without_valid actual=%0d required=0", bad_flag_cnt);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_uniform();
    // 000 at column 2, row 1 of a 3FF frame, erode.
    test_point("erode_pt", 10'h3FF, 10'h000, 1 * IW + 2, 1'b0);
    // 3FF at (0,0) of a 000 frame, dilate.
    test_point("dilate_pt", 10'h000, 10'h3FF, 0, 1'b1);
    test_random_frames();
    test_back_to_back_abort();
    test_reset_in_flush();
    test_flags_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
